console_probe: RTL

- Parametrised power-on console-type detector.
- It replaces the fixed inline new-famiclone detection in the cartridge top level.
- It grounds the CIRAM /CE and /A13 lines for a configurable number of M2 cycles, then samples the PPU address lines to decide whether the console drives PPU /A13 as the true complement of A13. A "new famiclone" does not.
- The result drives ppu_ciram_ce and ppu_not_a13_out muxing in the top level. It adds a sample window, a mismatch threshold, a timeout and a re-probe request.

---
 rtl/console_probe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/console_probe.sv
// Power-on console-type detector: grounds CIRAM /CE and /A13 during INIT,
// then samples PPU A13 against /A13 to tell a standard console from a
// new famiclone (which does not drive /A13 as the complement of A13).
module console_probe #(
  parameter int unsigned INIT_CYCLES        = 15,
  parameter int unsigned SAMPLES_PER_LEVEL  = 3,
  parameter int unsigned MISMATCH_THRESHOLD = 1,
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned PROBE_TIMEOUT      = 65535
) (
  input  logic       m2,
  input  logic       reset_n,
  input  logic       ppu_rd_in,
  input  logic       ppu_a13,
  input  logic       ppu_not_a13,
  input  logic       reprobe,
  output logic       ground_en,
  output logic       init_done,
  output logic       probe_done,
  output logic       new_dendy,
  output logic       probe_timeout,
  output logic [1:0] state
);

  localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int unsigned LVL_W  = $clog2(SAMPLES_PER_LEVEL + 1);
  localparam int unsigned MIS_W  = $clog2(MISMATCH_THRESHOLD + 1);
  localparam int unsigned TO_W   = $clog2(PROBE_TIMEOUT + 1);

  localparam logic [INIT_W-1:0] INIT_MAX = INIT_W'(INIT_CYCLES);
  localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(SAMPLES_PER_LEVEL);
  localparam logic [MIS_W-1:0]  MIS_MAX  = MIS_W'(MISMATCH_THRESHOLD);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(PROBE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_PROBE = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] rd_sync, a13_sync, na13_sync;
  logic s_rd, s_a13, s_na13;

  state_t             state_q, state_d;
  logic [INIT_W-1:0]  init_q, init_d;
  logic [LVL_W-1:0]   lvl0_q, lvl0_d, lvl1_q, lvl1_d;
  logic [MIS_W-1:0]   mis_q, mis_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic ground_q, ground_d, init_done_q, init_done_d;
  logic probe_done_q, probe_done_d, new_dendy_q, new_dendy_d;
  logic timeout_q, timeout_d;
  logic lvl0_open, lvl1_open;

  // Bring the raw PPU pins into the M2 domain; reprobe leaves these alone.
  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      rd_sync   <= '1;
      a13_sync  <= '0;
      na13_sync <= '1;
    end else begin
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], ppu_rd_in};
      a13_sync  <= {a13_sync[SYNC_STAGES-2:0], ppu_a13};
      na13_sync <= {na13_sync[SYNC_STAGES-2:0], ppu_not_a13};
    end
  end

  assign s_rd   = rd_sync[SYNC_STAGES-1];
  assign s_a13  = a13_sync[SYNC_STAGES-1];
  assign s_na13 = na13_sync[SYNC_STAGES-1];

  // State, counters and registered outputs.
  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      init_q       <= INIT_MAX;
      lvl0_q       <= '0;
      lvl1_q       <= '0;
      mis_q        <= '0;
      to_q         <= '0;
      ground_q     <= 1'b1;
      init_done_q  <= 1'b0;
      probe_done_q <= 1'b0;
      new_dendy_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_q       <= init_d;
      lvl0_q       <= lvl0_d;
      lvl1_q       <= lvl1_d;
      mis_q        <= mis_d;
      to_q         <= to_d;
      ground_q     <= ground_d;
      init_done_q  <= init_done_d;
      probe_done_q <= probe_done_d;
      new_dendy_q  <= new_dendy_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state and next-output logic; reprobe overrides every state.
  always_comb begin
    state_d      = state_q;
    init_d       = init_q;
    lvl0_d       = lvl0_q;
    lvl1_d       = lvl1_q;
    mis_d        = mis_q;
    to_d         = to_q;
    ground_d     = ground_q;
    init_done_d  = init_done_q;
    probe_done_d = probe_done_q;
    new_dendy_d  = new_dendy_q;
    timeout_d    = timeout_q;
    lvl0_open    = (lvl0_q < LVL_MAX);
    lvl1_open    = (lvl1_q < LVL_MAX);

    if (reprobe) begin
      state_d      = ST_INIT;
      init_d       = INIT_MAX;
      lvl0_d       = '0;
      lvl1_d       = '0;
      mis_d        = '0;
      to_d         = '0;
      ground_d     = 1'b1;
      init_done_d  = 1'b0;
      probe_done_d = 1'b0;
      new_dendy_d  = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_q > INIT_W'(1)) begin
            init_d = init_q - INIT_W'(1);
          end else begin
            init_d      = '0;
            state_d     = ST_PROBE;
            ground_d    = 1'b0;
            init_done_d = 1'b1;
          end
        end
        ST_PROBE: begin
          if (to_q != TO_MAX) to_d = to_q + TO_W'(1);
          if (!s_rd) begin
            if (!s_a13 && lvl0_open) lvl0_d = lvl0_q + LVL_W'(1);
            if (s_a13 && lvl1_open)  lvl1_d = lvl1_q + LVL_W'(1);
            // Mismatches only count while both levels are still collecting.
            if ((s_a13 == s_na13) && lvl0_open && lvl1_open && (mis_q < MIS_MAX))
              mis_d = mis_q + MIS_W'(1);
          end
          if (mis_d == MIS_MAX) new_dendy_d = 1'b1;
          if ((lvl0_d == LVL_MAX) && (lvl1_d == LVL_MAX)) begin
            state_d      = ST_DONE;
            probe_done_d = 1'b1;
          end else if (to_d == TO_MAX) begin
            state_d      = ST_DONE;
            probe_done_d = 1'b1;
            timeout_d    = 1'b1;
          end
        end
        ST_DONE: begin
        end
        default: begin
          state_d = ST_INIT;
          init_d  = INIT_MAX;
        end
      endcase
    end
  end

  assign ground_en     = ground_q;
  assign init_done     = init_done_q;
  assign probe_done    = probe_done_q;
  assign new_dendy     = new_dendy_q;
  assign probe_timeout = timeout_q;
  assign state         = state_q;

endmodule
